// File: rtl/my_alu_pkg.sv
// Shared definitions for the 8-bit registered ALU: default width, the
// opcode encoding and the flag bundle passed from the datapath to the
// output register.
package my_alu_pkg;

  // Default operand/result width used by every file of the ALU.
  localparam int DEFAULT_WIDTH = 8;

  // Operation select. Every 3-bit value is a legal operation, so the
  // datapath never has an undefined case.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opCode_e;

  // Status flags produced alongside each result.
  typedef struct packed {
    logic carry;
    logic sign;
    logic over;
  } aluFlags_t;

  // True for the two arithmetic operations, the only ones that can
  // report a signed overflow.
  function automatic logic isArith(input opCode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/my_alu_core.sv
// Purely combinational result and flag generator. The carry output is
// the carry out of ADD, the borrow of SUB, or the bit shifted out by a
// shift; overflow is only meaningful for ADD and SUB.
module my_alu_core
  import my_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       opCode_i,
  output logic [WIDTH-1:0] result_o,
  output aluFlags_t        flags_o
);

  opCode_e          opSel;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;
  logic             carryBit;
  logic             addOver;
  logic             subOver;

  assign opSel = opCode_e'(opCode_i);

  // Both arithmetic paths are computed one bit wider than the operands so
  // the extra MSB is directly the carry out (ADD) or the borrow (SUB).
  always_comb begin
    sumExt  = {1'b0, a_i} + {1'b0, b_i};
    diffExt = {1'b0, a_i} - {1'b0, b_i};
  end

  // Signed overflow: ADD overflows when both operands share a sign that
  // the result does not; SUB overflows when the operands differ in sign
  // and the result's sign differs from A.
  always_comb begin
    addOver = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
              (sumExt[WIDTH-1] != a_i[WIDTH-1]);
    subOver = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
              (diffExt[WIDTH-1] != a_i[WIDTH-1]);
  end

  // Result and carry selection. Logic ops and NOT clear carry; the
  // default arm only exists to keep the selection fully defined.
  always_comb begin
    result_o = '0;
    carryBit = 1'b0;
    case (opSel)
      OP_ADD: begin
        result_o = sumExt[WIDTH-1:0];
        carryBit = sumExt[WIDTH];
      end
      OP_SUB: begin
        result_o = diffExt[WIDTH-1:0];
        carryBit = diffExt[WIDTH];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        carryBit = a_i[WIDTH-1];
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        carryBit = a_i[0];
      end
      default: begin
        result_o = '0;
        carryBit = 1'b0;
      end
    endcase
  end

  // Flag bundle: sign always mirrors the result MSB, overflow is gated to
  // the arithmetic operations.
  always_comb begin
    flags_o.carry = carryBit;
    flags_o.sign  = result_o[WIDTH-1];
    flags_o.over  = 1'b0;
    if (isArith(opSel)) begin
      flags_o.over = (opSel == OP_ADD) ? addOver : subOver;
    end
  end

endmodule

// File: rtl/my_alu.sv
// Registered ALU: operands and opcode are sampled on every rising clock
// edge and the result plus flags appear one cycle later. An active-low
// asynchronous reset clears all outputs immediately and drops whatever
// result was about to be shown.
module my_alu
  import my_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opCode,
  output logic             carry,
  output logic             sign,
  output logic             over,
  output logic [WIDTH-1:0] myOut
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  aluFlags_t        flags_d;
  aluFlags_t        flags_q;

  my_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i      (A),
    .b_i      (B),
    .opCode_i (opCode),
    .result_o (result_d),
    .flags_o  (flags_d)
  );

  // Output register: captures a new operation every cycle, no handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign myOut = result_q;
  assign carry = flags_q.carry;
  assign sign  = flags_q.sign;
  assign over  = flags_q.over;

endmodule

// File: tb/tb_my_alu.sv
// Self-checking bench for my_alu. Expected results are computed from an
// integer model (or taken from hand-worked vectors) when stimulus is
// driven, queued, and popped when the registered output becomes valid.
module tb_my_alu;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       s;
    logic       o;
  } expect_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] out;
    logic       c;
    logic       s;
    logic       o;
  } vector_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] opCode;
  logic       carry;
  logic       sign;
  logic       over;
  logic [7:0] myOut;

  expect_t expQ[$];
  string   tagQ[$];
  int      testsRun;
  int      testsFailed;

  my_alu #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .opCode (opCode),
    .carry  (carry),
    .sign   (sign),
    .over   (over),
    .myOut  (myOut)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent integer reference: arithmetic flags come from unsigned
  // and signed range checks rather than bit manipulation.
  function automatic expect_t model(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] op);
    expect_t m;
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    m  = '0;
    r  = 0;
    case (op)
      3'd0: begin
        r   = ua + ub;
        m.c = (r > 255);
        m.o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd1: begin
        r   = ua - ub;
        m.c = (ua < ub);
        m.o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 255 - ua;
      3'd6: begin
        r   = ua * 2;
        m.c = (ua >= 128);
      end
      default: begin
        r   = ua / 2;
        m.c = (ua % 2) == 1;
      end
    endcase
    m.out = 8'(r & 255);
    m.s   = (m.out >= 8'd128);
    return m;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive operands and queue the model's prediction for the next edge.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] op);
    A      = a;
    B      = b;
    opCode = op;
    expQ.push_back(model(a, b, op));
    tagQ.push_back(tag);
  endtask

  // Drive operands and queue a hand-worked expectation.
  task automatic applyDirected(input string tag, input vector_t v);
    A      = v.a;
    B      = v.b;
    opCode = v.op;
    expQ.push_back('{out: v.out, c: v.c, s: v.s, o: v.o});
    tagQ.push_back(tag);
  endtask

  // Advance one edge, then pop the oldest prediction and compare.
  task automatic stepAndCompare();
    expect_t e;
    string   t;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, ".myOut"}, 32'(myOut), 32'(e.out));
      checkOutput({t, ".carry"}, 32'(carry), 32'(e.c));
      checkOutput({t, ".sign"},  32'(sign),  32'(e.s));
      checkOutput({t, ".over"},  32'(over),  32'(e.o));
    end
  endtask

  // All outputs must read zero right now.
  task automatic checkZero(input string tag);
    checkOutput({tag, ".myOut"}, 32'(myOut), 32'd0);
    checkOutput({tag, ".carry"}, 32'(carry), 32'd0);
    checkOutput({tag, ".sign"},  32'(sign),  32'd0);
    checkOutput({tag, ".over"},  32'(over),  32'd0);
  endtask

  vector_t directed[15];
  string   dirTag[15];

  // Main sequence: reset, directed vectors, random traffic, pipelined
  // sequence with a mid-stream reset.
  initial begin
    testsRun    = 0;
    testsFailed = 0;

    //               a      b      op     out    c     s     o
    directed[0]  = '{8'h28, 8'h23, 3'd0, 8'h4B, 1'b0, 1'b0, 1'b0}; dirTag[0]  = "add_small";
    directed[1]  = '{8'h4A, 8'h57, 3'd0, 8'hA1, 1'b0, 1'b1, 1'b1}; dirTag[1]  = "add_ovf";
    directed[2]  = '{8'hCA, 8'h67, 3'd0, 8'h31, 1'b1, 1'b0, 1'b0}; dirTag[2]  = "add_carry";
    directed[3]  = '{8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}; dirTag[3]  = "add_zero";
    directed[4]  = '{8'h2A, 8'h67, 3'd1, 8'hC3, 1'b1, 1'b1, 1'b0}; dirTag[4]  = "sub_borrow";
    directed[5]  = '{8'h80, 8'h07, 3'd1, 8'h79, 1'b0, 1'b0, 1'b1}; dirTag[5]  = "sub_ovf";
    directed[6]  = '{8'hB0, 8'hCF, 3'd1, 8'hE1, 1'b1, 1'b1, 1'b0}; dirTag[6]  = "sub_neg";
    directed[7]  = '{8'h70, 8'h1B, 3'd2, 8'h10, 1'b0, 1'b0, 1'b0}; dirTag[7]  = "and";
    directed[8]  = '{8'h06, 8'h09, 3'd3, 8'h0F, 1'b0, 1'b0, 1'b0}; dirTag[8]  = "or";
    directed[9]  = '{8'h70, 8'h0F, 3'd4, 8'h7F, 1'b0, 1'b0, 1'b0}; dirTag[9]  = "xor";
    directed[10] = '{8'h70, 8'hFF, 3'd5, 8'h8F, 1'b0, 1'b1, 1'b0}; dirTag[10] = "not";
    directed[11] = '{8'h30, 8'hFF, 3'd6, 8'h60, 1'b0, 1'b0, 1'b0}; dirTag[11] = "shl";
    directed[12] = '{8'h81, 8'hFF, 3'd7, 8'h40, 1'b1, 1'b0, 1'b0}; dirTag[12] = "shr_c1";
    directed[13] = '{8'h80, 8'h00, 3'd7, 8'h40, 1'b0, 1'b0, 1'b0}; dirTag[13] = "shr_c0";
    directed[14] = '{8'hC0, 8'h55, 3'd6, 8'h80, 1'b1, 1'b1, 1'b0}; dirTag[14] = "shl_c1";

    // Reset asserted at time 0 with non-zero inputs: outputs clear before
    // any clock edge arrives.
    rst_n  = 1'b0;
    A      = 8'hFF;
    B      = 8'h01;
    opCode = 3'b000;
    #1;
    checkZero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset_held");

    // Release away from the edge; first capture is FF+01.
    @(negedge clk);
    rst_n = 1'b1;
    applyDirected("reset_release", '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0});
    stepAndCompare();

    // Directed vectors, one per cycle.
    for (int i = 0; i < 15; i++) begin
      applyDirected(dirTag[i], directed[i]);
      stepAndCompare();
    end

    // Random traffic across all opcodes.
    for (int i = 0; i < 200; i++) begin
      applyStimulus("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    3'($urandom_range(0, 7)));
      stepAndCompare();
    end

    // Back-to-back ADD/SUB/SHL with operands changing every cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("pipe_add", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'd0);
      stepAndCompare();
      applyStimulus("pipe_sub", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'd1);
      stepAndCompare();
      applyStimulus("pipe_shl", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'd6);
      stepAndCompare();
    end

    // Leave a non-zero result showing, then reset mid-stream.
    applyDirected("pre_reset", '{8'hCA, 8'h67, 3'd0, 8'h31, 1'b1, 1'b0, 1'b0});
    stepAndCompare();
    applyStimulus("inflight", 8'h7F, 8'h01, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("reset_midstream");
    expQ.delete();
    tagQ.delete();
    @(posedge clk);
    #1;
    checkZero("reset_mid_held");

    // First edge after release reflects the inputs present at that edge.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_reset_sub", 8'h10, 8'h20, 3'd1);
    stepAndCompare();
    applyStimulus("post_reset_shr", 8'h03, 8'h00, 3'd7);
    stepAndCompare();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
